// File: rtl/esm_pkg.sv
//------------------------------------------------------------------------------
// Module  : esm_pkg
// Brief   : Shared ESM types and constants: control-message header layout,
//           router state encoding and destination module ids.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package esm_pkg;

    localparam logic [31:0] esm_control_magic_num    = 32'hE5C0_A55A;
    localparam int          esm_control_header_words = 4;

    localparam logic [7:0] esm_module_id_dwell_ctrl  = 8'd0;
    localparam logic [7:0] esm_module_id_channelizer = 8'd1;
    localparam logic [7:0] esm_module_id_pulse_det   = 8'd2;
    localparam logic [7:0] esm_module_id_status_rpt  = 8'd3;

    typedef enum logic [2:0] {
        S_MAGIC   = 3'd0,
        S_SEQ     = 3'd1,
        S_TYPE    = 3'd2,
        S_PAD     = 3'd3,
        S_PAYLOAD = 3'd4,
        S_DROP    = 3'd5
    } esm_config_router_state_t;

    typedef struct packed {
        logic [31:0] magic;
        logic [31:0] seq;
        logic [7:0]  module_id;
        logic [7:0]  msg_type;
    } esm_control_header_t;

endpackage

`default_nettype wire

// File: rtl/esm_config_router_if.sv
//------------------------------------------------------------------------------
// Module  : esm_config_router_if
// Brief   : Config AXI-stream input plus broadcast config bus output.
//           master = stream source / config sink, slave = router.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface esm_config_router_if #(
    parameter int NUM_MODULES = 4,
    parameter int IDX_W       = 6
);
    logic                   S_axis_valid;
    logic                   S_axis_ready;
    logic [31:0]            S_axis_data;
    logic                   S_axis_last;

    logic                   Cfg_valid;
    logic [NUM_MODULES-1:0] Cfg_module_sel;
    logic [7:0]             Cfg_msg_type;
    logic [31:0]            Cfg_data;
    logic                   Cfg_first;
    logic                   Cfg_last;
    logic [IDX_W-1:0]       Cfg_word_index;

    modport master (
        output S_axis_valid, S_axis_data, S_axis_last,
        input  S_axis_ready,
        input  Cfg_valid, Cfg_module_sel, Cfg_msg_type, Cfg_data,
               Cfg_first, Cfg_last, Cfg_word_index
    );

    modport slave (
        input  S_axis_valid, S_axis_data, S_axis_last,
        output S_axis_ready,
        output Cfg_valid, Cfg_module_sel, Cfg_msg_type, Cfg_data,
               Cfg_first, Cfg_last, Cfg_word_index
    );
endinterface

`default_nettype wire

// File: rtl/esm_sat_counter.sv
//------------------------------------------------------------------------------
// Module  : esm_sat_counter
// Brief   : Event counter that sticks at all-ones instead of wrapping.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module esm_sat_counter #(
    parameter int WIDTH = 16
) (
    input  wire logic             Clk,
    input  wire logic             Rstn,
    input  wire logic             inc,
    output logic [WIDTH-1:0]      count
);
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge Clk or negedge Rstn) begin
        if (!Rstn) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
endmodule

`default_nettype wire

// File: rtl/esm_config_router.sv
//------------------------------------------------------------------------------
// Module  : esm_config_router
// Brief   : Validates ESM control-message headers and broadcasts payload words
//           to the addressed sub-block; malformed messages feed error counters.
//           Optional macro ESM_CONFIG_ROUTER_SEQ_CHECK_EN adds sequence checking.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module esm_config_router
    import esm_pkg::*;
#(
    parameter int AXI_DATA_WIDTH    = 32,
    parameter int NUM_MODULES       = 4,
    parameter int MAX_PAYLOAD_WORDS = 64
) (
    input  wire logic             Clk,
    input  wire logic             Rstn,
    esm_config_router_if.slave    bus,
    output logic [15:0]           Err_magic_count,
    output logic [15:0]           Err_module_count,
    output logic [15:0]           Err_length_count,
    output logic [31:0]           Msg_count
`ifdef ESM_CONFIG_ROUTER_SEQ_CHECK_EN
    ,
    output logic [15:0]           Err_seq_count
`endif
);
    localparam int                     IDX_W    = $clog2(MAX_PAYLOAD_WORDS);
    localparam logic [IDX_W-1:0]       LAST_IDX = IDX_W'(MAX_PAYLOAD_WORDS - 1);
    localparam logic [NUM_MODULES-1:0] SEL_ONE  = NUM_MODULES'(1);

    esm_config_router_state_t state_q, state_d;

    logic                      ready_q, ready_d;
    logic [7:0]                module_id_q, module_id_d;
    logic [7:0]                hdr_type_q, hdr_type_d;
    logic [IDX_W-1:0]          word_cnt_q, word_cnt_d;
    logic                      cfg_valid_q, cfg_valid_d;
    logic [NUM_MODULES-1:0]    cfg_sel_q, cfg_sel_d;
    logic [7:0]                cfg_type_q, cfg_type_d;
    logic [AXI_DATA_WIDTH-1:0] cfg_data_q, cfg_data_d;
    logic                      cfg_first_q, cfg_first_d;
    logic                      cfg_last_q, cfg_last_d;
    logic [IDX_W-1:0]          cfg_idx_q, cfg_idx_d;

    logic beat;
    logic inc_magic, inc_module, inc_length, inc_msg;

`ifdef ESM_CONFIG_ROUTER_SEQ_CHECK_EN
    logic [31:0] seq_q, seq_d;
    logic [31:0] exp_seq_q, exp_seq_d;
    logic        exp_vld_q, exp_vld_d;
    logic        inc_seq;
`endif

    assign beat = bus.S_axis_valid & ready_q;

    always_comb begin
        state_d     = state_q;
        ready_d     = 1'b1;
        module_id_d = module_id_q;
        hdr_type_d  = hdr_type_q;
        word_cnt_d  = word_cnt_q;
        cfg_valid_d = 1'b0;
        cfg_sel_d   = '0;
        cfg_type_d  = cfg_type_q;
        cfg_data_d  = cfg_data_q;
        cfg_first_d = 1'b0;
        cfg_last_d  = 1'b0;
        cfg_idx_d   = cfg_idx_q;
        inc_magic   = 1'b0;
        inc_module  = 1'b0;
        inc_length  = 1'b0;
        inc_msg     = 1'b0;
`ifdef ESM_CONFIG_ROUTER_SEQ_CHECK_EN
        seq_d       = seq_q;
        exp_seq_d   = exp_seq_q;
        exp_vld_d   = exp_vld_q;
        inc_seq     = 1'b0;
`endif

        if (beat) begin
            // A last inside the header outranks any other header fault.
            if (bus.S_axis_last && (state_q inside {S_MAGIC, S_SEQ, S_TYPE, S_PAD})) begin
                inc_length = 1'b1;
                state_d    = S_MAGIC;
            end else begin
                case (state_q)
                    S_MAGIC: begin
                        if (bus.S_axis_data == esm_control_magic_num) begin
                            state_d = S_SEQ;
                        end else begin
                            inc_magic = 1'b1;
                            state_d   = S_DROP;
                        end
                    end
                    S_SEQ: begin
`ifdef ESM_CONFIG_ROUTER_SEQ_CHECK_EN
                        seq_d   = bus.S_axis_data;
`endif
                        state_d = S_TYPE;
                    end
                    S_TYPE: begin
                        module_id_d = bus.S_axis_data[31:24];
                        hdr_type_d  = bus.S_axis_data[23:16];
                        word_cnt_d  = '0;
                        if ({24'd0, bus.S_axis_data[31:24]} >= NUM_MODULES) begin
                            inc_module = 1'b1;
                            state_d    = S_DROP;
                        end else begin
                            state_d = S_PAD;
                        end
                    end
                    S_PAD: begin
`ifdef ESM_CONFIG_ROUTER_SEQ_CHECK_EN
                        // Header is complete here; mismatch resyncs rather than drops.
                        if (exp_vld_q && (seq_q != exp_seq_q)) begin
                            inc_seq = 1'b1;
                        end
                        exp_seq_d = seq_q + 32'd1;
                        exp_vld_d = 1'b1;
`endif
                        state_d = S_PAYLOAD;
                    end
                    S_PAYLOAD: begin
                        cfg_valid_d = 1'b1;
                        cfg_sel_d   = SEL_ONE << module_id_q;
                        cfg_type_d  = hdr_type_q;
                        cfg_data_d  = bus.S_axis_data;
                        cfg_first_d = (word_cnt_q == '0);
                        cfg_last_d  = bus.S_axis_last || (word_cnt_q == LAST_IDX);
                        cfg_idx_d   = word_cnt_q;
                        word_cnt_d  = word_cnt_q + 1'b1;
                        if (bus.S_axis_last) begin
                            inc_msg = 1'b1;
                            state_d = S_MAGIC;
                        end else if (word_cnt_q == LAST_IDX) begin
                            inc_length = 1'b1;
                            state_d    = S_DROP;
                        end
                    end
                    S_DROP: begin
                        if (bus.S_axis_last) begin
                            state_d = S_MAGIC;
                        end
                    end
                    default: state_d = S_MAGIC;
                endcase
            end
        end
    end

    always_ff @(posedge Clk or negedge Rstn) begin
        if (!Rstn) begin
            state_q     <= S_MAGIC;
            ready_q     <= 1'b0;
            module_id_q <= '0;
            hdr_type_q  <= '0;
            word_cnt_q  <= '0;
            cfg_valid_q <= 1'b0;
            cfg_sel_q   <= '0;
            cfg_type_q  <= '0;
            cfg_data_q  <= '0;
            cfg_first_q <= 1'b0;
            cfg_last_q  <= 1'b0;
            cfg_idx_q   <= '0;
        end else begin
            state_q     <= state_d;
            ready_q     <= ready_d;
            module_id_q <= module_id_d;
            hdr_type_q  <= hdr_type_d;
            word_cnt_q  <= word_cnt_d;
            cfg_valid_q <= cfg_valid_d;
            cfg_sel_q   <= cfg_sel_d;
            cfg_type_q  <= cfg_type_d;
            cfg_data_q  <= cfg_data_d;
            cfg_first_q <= cfg_first_d;
            cfg_last_q  <= cfg_last_d;
            cfg_idx_q   <= cfg_idx_d;
        end
    end

`ifdef ESM_CONFIG_ROUTER_SEQ_CHECK_EN
    always_ff @(posedge Clk or negedge Rstn) begin
        if (!Rstn) begin
            seq_q     <= '0;
            exp_seq_q <= '0;
            exp_vld_q <= 1'b0;
        end else begin
            seq_q     <= seq_d;
            exp_seq_q <= exp_seq_d;
            exp_vld_q <= exp_vld_d;
        end
    end

    esm_sat_counter #(.WIDTH(16)) u_err_seq (
        .Clk(Clk), .Rstn(Rstn), .inc(inc_seq), .count(Err_seq_count)
    );
`endif

    esm_sat_counter #(.WIDTH(16)) u_err_magic (
        .Clk(Clk), .Rstn(Rstn), .inc(inc_magic), .count(Err_magic_count)
    );
    esm_sat_counter #(.WIDTH(16)) u_err_module (
        .Clk(Clk), .Rstn(Rstn), .inc(inc_module), .count(Err_module_count)
    );
    esm_sat_counter #(.WIDTH(16)) u_err_length (
        .Clk(Clk), .Rstn(Rstn), .inc(inc_length), .count(Err_length_count)
    );
    esm_sat_counter #(.WIDTH(32)) u_msg (
        .Clk(Clk), .Rstn(Rstn), .inc(inc_msg), .count(Msg_count)
    );

    assign bus.S_axis_ready   = ready_q;
    assign bus.Cfg_valid      = cfg_valid_q;
    assign bus.Cfg_module_sel = cfg_sel_q;
    assign bus.Cfg_msg_type   = cfg_type_q;
    assign bus.Cfg_data       = cfg_data_q;
    assign bus.Cfg_first      = cfg_first_q;
    assign bus.Cfg_last       = cfg_last_q;
    assign bus.Cfg_word_index = cfg_idx_q;
endmodule

`default_nettype wire

// File: tb/tb_esm_config_router.sv
//------------------------------------------------------------------------------
// Module  : tb_esm_config_router
// Brief   : Directed self-checking bench for esm_config_router.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_esm_config_router;
    import esm_pkg::*;

    localparam int NM   = 4;
    localparam int MAXW = 64;
    localparam int IDXW = 6;
    localparam logic [31:0] MAGIC = 32'hE5C0_A55A;

    logic        Clk  = 1'b0;
    logic        Rstn = 1'b0;
    logic [15:0] err_magic, err_module, err_length;
    logic [31:0] msg_count;
`ifdef ESM_CONFIG_ROUTER_SEQ_CHECK_EN
    logic [15:0] err_seq;
`endif

    esm_config_router_if #(.NUM_MODULES(NM), .IDX_W(IDXW)) bus ();

    esm_config_router #(
        .AXI_DATA_WIDTH(32), .NUM_MODULES(NM), .MAX_PAYLOAD_WORDS(MAXW)
    ) dut (
        .Clk              (Clk),
        .Rstn             (Rstn),
        .bus              (bus),
        .Err_magic_count  (err_magic),
        .Err_module_count (err_module),
        .Err_length_count (err_length),
        .Msg_count        (msg_count)
`ifdef ESM_CONFIG_ROUTER_SEQ_CHECK_EN
        ,
        .Err_seq_count    (err_seq)
`endif
    );

    always #5 Clk = ~Clk;

    int checks = 0;
    int errors = 0;
    logic [63:0] rx_q[$];
    logic [63:0] exp_q[$];

    function automatic logic [63:0] pack_word(input logic [3:0] sel, input logic first,
                                              input logic last, input logic [5:0] idx,
                                              input logic [7:0] typ, input logic [31:0] data);
        return {4'd0, sel, first, last, idx, typ, data};
    endfunction

    always @(negedge Clk) begin
        if (bus.Cfg_valid) begin
            rx_q.push_back(pack_word(bus.Cfg_module_sel, bus.Cfg_first, bus.Cfg_last,
                                     bus.Cfg_word_index, bus.Cfg_msg_type, bus.Cfg_data));
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic beat(input logic [31:0] d, input logic l, input bit gaps);
        while (gaps && ($urandom_range(0, 99) < 20)) begin
            @(posedge Clk); #1;
        end
        bus.S_axis_valid = 1'b1;
        bus.S_axis_data  = d;
        bus.S_axis_last  = l;
        @(posedge Clk); #1;
        bus.S_axis_valid = 1'b0;
        bus.S_axis_last  = 1'b0;
    endtask

    task automatic send_msg(input logic [31:0] seq, input logic [7:0] mod, input logic [7:0] typ,
                            input int n, input logic [31:0] base, input bit gaps, input bit fwd);
        logic [3:0] sel;
        sel = 4'b0001 << mod;
        beat(MAGIC, 1'b0, gaps);
        beat(seq, 1'b0, gaps);
        beat({mod, typ, 16'h0}, 1'b0, gaps);
        beat(32'h0, n == 0, gaps);
        for (int i = 0; i < n; i++) begin
            beat(base + 32'(i), i == n - 1, gaps);
            if (fwd && i < MAXW)
                exp_q.push_back(pack_word(sel, i == 0, (i == n - 1) || (i == MAXW - 1),
                                          i[5:0], typ, base + 32'(i)));
        end
    endtask

    task automatic drain();
        repeat (3) @(posedge Clk);
        #1;
    endtask

    task automatic compare(input string tag);
        chk({tag, "_words"}, 64'(rx_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++)
            chk($sformatf("%s_w%0d", tag, i), rx_q[i], exp_q[i]);
        rx_q.delete();
        exp_q.delete();
    endtask

    task automatic do_reset();
        Rstn = 1'b0;
        bus.S_axis_valid = 1'b0;
        repeat (3) @(posedge Clk);
        #1 Rstn = 1'b1;
        repeat (2) @(posedge Clk);
        #1;
        rx_q.delete();
        exp_q.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.S_axis_valid = 1'b0;
        bus.S_axis_data  = '0;
        bus.S_axis_last  = 1'b0;
        #1;
        // Reset state
        chk("rst_ready", 64'(bus.S_axis_ready), 64'd0);
        chk("rst_valid", 64'(bus.Cfg_valid), 64'd0);
        chk("rst_counters", {err_magic, err_module, err_length, 16'd0} | 64'(msg_count), 64'd0);
        do_reset();
        chk("ready_after_rst", 64'(bus.S_axis_ready), 64'd1);

        // Valid message, 8 payload words to module 0
        send_msg(32'd0, 8'd0, 8'd1, 8, 32'hA000_0000, 1'b0, 1'b1);
        drain();
        compare("valid8");
        chk("valid8_msgcnt", 64'(msg_count), 64'd1);
        chk("idle_sel_zero", 64'(bus.Cfg_module_sel), 64'd0);
        chk("idle_type_held", 64'(bus.Cfg_msg_type), 64'd1);

        // Bad magic, 6 words, then a good message
        beat(32'h1234_5678, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) beat(32'h0300_0000, i == 4, 1'b0);
        send_msg(32'd1, 8'd2, 8'h33, 3, 32'hB000_0010, 1'b0, 1'b1);
        drain();
        compare("badmagic");
        chk("badmagic_cnt", 64'(err_magic), 64'd1);
        chk("badmagic_msgcnt", 64'(msg_count), 64'd2);

        // Module id out of range
        send_msg(32'd2, 8'd7, 8'h44, 5, 32'hC000_0000, 1'b0, 1'b0);
        drain();
        compare("badmod");
        chk("badmod_cnt", 64'(err_module), 64'd1);

        // Last during header (word 2), then header ending at pad
        beat(MAGIC, 1'b0, 1'b0);
        beat(32'd3, 1'b1, 1'b0);
        send_msg(32'd3, 8'd1, 8'h55, 0, 32'h0, 1'b0, 1'b0);
        drain();
        compare("short");
        chk("short_lencnt", 64'(err_length), 64'd2);
        chk("short_modcnt", 64'(err_module), 64'd1);
        chk("short_magcnt", 64'(err_magic), 64'd1);

        // 70-word payload truncated at 64, then a following message
        send_msg(32'd4, 8'd3, 8'h66, 70, 32'hD000_0000, 1'b0, 1'b1);
        send_msg(32'd5, 8'd1, 8'h77, 2, 32'hE000_0000, 1'b0, 1'b1);
        drain();
        compare("trunc");
        chk("trunc_lencnt", 64'(err_length), 64'd3);
        chk("trunc_msgcnt", 64'(msg_count), 64'd3);

        // 20 messages with random input gaps
        do_reset();
        for (int m = 0; m < 20; m++)
            send_msg(32'(m), 8'($urandom_range(0, 3)), 8'($urandom_range(0, 255)),
                     $urandom_range(1, 10), $urandom, 1'b1, 1'b1);
        drain();
        compare("rand20");
        chk("rand20_msgcnt", 64'(msg_count), 64'd20);

        // Reset pulse in the middle of a payload
        do_reset();
        beat(MAGIC, 1'b0, 1'b0);
        beat(32'd0, 1'b0, 1'b0);
        beat({8'd2, 8'd5, 16'h0}, 1'b0, 1'b0);
        beat(32'h0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) beat(32'h5000_0000 + 32'(i), 1'b0, 1'b0);
        chk("midrst_pre_valid", 64'(bus.Cfg_valid), 64'd1);
        Rstn = 1'b0;
        #1;
        chk("midrst_valid", 64'(bus.Cfg_valid), 64'd0);
        chk("midrst_sel", 64'(bus.Cfg_module_sel), 64'd0);
        chk("midrst_ready", 64'(bus.S_axis_ready), 64'd0);
        repeat (2) @(posedge Clk);
        #1 Rstn = 1'b1;
        repeat (2) @(posedge Clk);
        #1;
        rx_q.delete();
        exp_q.delete();
        send_msg(32'd0, 8'd1, 8'h21, 4, 32'h6000_0000, 1'b0, 1'b1);
        drain();
        compare("postrst");
        chk("postrst_msgcnt", 64'(msg_count), 64'd1);
        chk("postrst_lencnt", 64'(err_length), 64'd0);

`ifdef ESM_CONFIG_ROUTER_SEQ_CHECK_EN
        do_reset();
        send_msg(32'd0, 8'd0, 8'h01, 1, 32'h7000_0000, 1'b0, 1'b1);
        send_msg(32'd1, 8'd0, 8'h01, 1, 32'h7000_0100, 1'b0, 1'b1);
        send_msg(32'd3, 8'd0, 8'h01, 1, 32'h7000_0200, 1'b0, 1'b1);
        drain();
        compare("seq");
        chk("seq_errcnt", 64'(err_seq), 64'd1);
        chk("seq_msgcnt", 64'(msg_count), 64'd3);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

`default_nettype wire
